// File: rtl/dmemory_banked.sv
// Banked data memory: 32-bit words stored as four byte lanes, byte/half/word
// loads and stores with a single outstanding request. Stores and errored
// requests answer one cycle after acceptance; loads answer READ_LAT cycles
// after acceptance with the word captured at the acceptance edge.
module dmemory_banked #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_LAT    = 2
) (
  input  logic              ram_clk_i,
  input  logic              ram_rstn_i,
  input  logic              ram_req_i,
  input  logic              ram_wen_i,
  input  logic [1:0]        ram_dat_width,
  input  logic              ram_sign,
  input  logic [ADDR_W-1:0] ram_adr_i,
  input  logic [31:0]       ram_dat_i,
  output logic              ram_ready_o,
  output logic              ram_vld_o,
  output logic              ram_err_o,
  output logic [31:0]       ram_dat_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH_WORDS) * 64'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic [31:0]     word_q;
  logic [1:0]      off_q;
  logic [1:0]      width_q;
  logic            sign_q;
  logic            vld_q;
  logic            err_q;
  logic [31:0]     dat_q;

  logic [3:0][7:0] mem_q [DEPTH_WORDS];

  logic             accept;
  logic             misalign;
  logic             out_of_range;
  logic             req_err;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be_d;
  logic [31:0]      wlane_d;
  logic [31:0]      rd_word;

  // Extract the addressed byte or halfword, move it to bit 0 and extend it.
  function automatic logic [31:0] load_fmt(input logic [31:0] w,
                                           input logic [1:0]  off,
                                           input logic [1:0]  width,
                                           input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (width)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign idx          = ram_adr_i[IDX_W+1:2];
  assign misalign     = ((ram_dat_width == 2'd1) && ram_adr_i[0]) ||
                        (ram_dat_width[1] && (ram_adr_i[1:0] != 2'b00));
  assign out_of_range = 64'(ram_adr_i) >= MEM_BYTES;
  assign req_err      = misalign || out_of_range;
  // Holding reset low also blocks acceptance in the same cycle.
  assign ram_ready_o  = (state_q == S_IDLE) && ram_rstn_i;
  assign accept       = ram_req_i && ram_ready_o;
  assign rd_word      = mem_q[idx];

  // Byte-lane enables and lane-replicated store data for the addressed size.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    be_d    = 4'b1111;
    wlane_d = ram_dat_i;
    case (ram_dat_width)
      2'd0: begin
        be_d    = 4'b0001 << ram_adr_i[1:0];
        wlane_d = {4{ram_dat_i[7:0]}};
      end
      2'd1: begin
        be_d    = ram_adr_i[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{ram_dat_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Store commit: only enabled lanes of a valid store change, at acceptance.
  // NOTE: the array is deliberately not reset; clearing it would force flops instead of RAM.
  always_ff @(posedge ram_clk_i) begin
    if (accept && ram_wen_i && !req_err) begin
      for (int l = 0; l < 4; l++) begin
        if (be_d[l]) mem_q[idx][l] <= wlane_d[8*l +: 8];
      end
    end
  end

  // Request FSM with registered response outputs, raised only on entry to RESP.
  always_ff @(posedge ram_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!ram_rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      word_q  <= 32'd0;
      off_q   <= 2'd0;
      width_q <= 2'd0;
      sign_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= 32'd0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            word_q  <= rd_word;
            off_q   <= ram_adr_i[1:0];
            width_q <= ram_dat_width;
            sign_q  <= ram_sign;
            if (req_err) begin
              state_q <= S_RESP;
              vld_q   <= 1'b1;
              err_q   <= 1'b1;
            end else if (ram_wen_i) begin
              state_q <= S_RESP;
              vld_q   <= 1'b1;
            end else if (READ_LAT == 1) begin
              state_q <= S_RESP;
              vld_q   <= 1'b1;
              dat_q   <= load_fmt(rd_word, ram_adr_i[1:0], ram_dat_width, ram_sign);
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= 3'(READ_LAT - 1);
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= S_RESP;
            vld_q   <= 1'b1;
            dat_q   <= load_fmt(word_q, off_q, width_q, sign_q);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_vld_o = vld_q;
  assign ram_err_o = err_q;
  assign ram_dat_o = dat_q;

endmodule

// File: tb/tb_dmemory_banked.sv
// Bench for dmemory_banked: three instances (READ_LAT 1, 2, 4) share one
// stimulus stream; a byte-array reference model produces expected responses
// that are queued per instance and checked by independent monitors.
module tb_dmemory_banked;

  localparam int DEPTH = 1024;
  localparam int NBYTES = 4 * DEPTH;

  typedef struct packed {
    logic        err;
    logic        slow;
    logic [31:0] dat;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic        sgn = 1'b0;
  logic [1:0]  width = 2'd0;
  logic [15:0] adr = 16'd0;
  logic [31:0] wdat = 32'd0;

  logic [2:0]  ready;
  logic [2:0]  vld;
  logic [2:0]  err;
  logic [31:0] dat [3];

  exp_t        exp_q [3][$];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  mem_m [NBYTES];

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  dmemory_banked #(.ADDR_W(16), .DEPTH_WORDS(DEPTH), .READ_LAT(1)) u_l1 (
    .ram_clk_i(clk), .ram_rstn_i(rstn), .ram_req_i(req), .ram_wen_i(wen),
    .ram_dat_width(width), .ram_sign(sgn), .ram_adr_i(adr), .ram_dat_i(wdat),
    .ram_ready_o(ready[0]), .ram_vld_o(vld[0]), .ram_err_o(err[0]), .ram_dat_o(dat[0]));

  dmemory_banked #(.ADDR_W(16), .DEPTH_WORDS(DEPTH), .READ_LAT(2)) u_l2 (
    .ram_clk_i(clk), .ram_rstn_i(rstn), .ram_req_i(req), .ram_wen_i(wen),
    .ram_dat_width(width), .ram_sign(sgn), .ram_adr_i(adr), .ram_dat_i(wdat),
    .ram_ready_o(ready[1]), .ram_vld_o(vld[1]), .ram_err_o(err[1]), .ram_dat_o(dat[1]));

  dmemory_banked #(.ADDR_W(16), .DEPTH_WORDS(DEPTH), .READ_LAT(4)) u_l4 (
    .ram_clk_i(clk), .ram_rstn_i(rstn), .ram_req_i(req), .ram_wen_i(wen),
    .ram_dat_width(width), .ram_sign(sgn), .ram_adr_i(adr), .ram_dat_i(wdat),
    .ram_ready_o(ready[2]), .ram_vld_o(vld[2]), .ram_err_o(err[2]), .ram_dat_o(dat[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: memory as a flat little-endian byte array.
  function automatic exp_t model(input logic w, input logic [1:0] wd, input logic s,
                                 input logic [15:0] a, input logic [31:0] d);
    exp_t        e;
    int          n;
    logic [31:0] v;
    n      = (wd == 2'd0) ? 1 : ((wd == 2'd1) ? 2 : 4);
    e.acc  = 32'd0;
    e.dat  = 32'd0;
    e.err  = ((int'(a) % n) != 0) || (int'(a) >= NBYTES);
    e.slow = !w && !e.err;
    if (!e.err) begin
      if (w) begin
        for (int i = 0; i < n; i++) mem_m[int'(a) + i] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[int'(a) + i];
        if (s && n < 4 && v[8*n-1]) begin
          for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        e.dat = v;
      end
    end
    return e;
  endfunction

  // Per-instance monitors: reset aborts outstanding requests; otherwise each
  // response is popped and compared when vld is seen.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    exp_t e;
    int   age;
    int   want;

    always @(posedge clk) begin
      if (!rstn) exp_q[gi].delete();
    end

    always @(negedge clk) begin
      if (mon_en) begin
        if (exp_q[gi].size() != 0) begin
          e    = exp_q[gi][0];
          age  = cycle - int'(e.acc) + 1;
          want = e.slow ? lat_of(gi) : 1;
          check($sformatf("ready_low_L%0d", lat_of(gi)), 32'(ready[gi]), 32'd0);
          if (vld[gi] === 1'b1) begin
            void'(exp_q[gi].pop_front());
            check($sformatf("latency_L%0d", lat_of(gi)), 32'(age), 32'(want));
            check($sformatf("err_L%0d", lat_of(gi)), 32'(err[gi]), 32'(e.err));
            check($sformatf("dat_L%0d", lat_of(gi)), dat[gi], e.dat);
          end else if (age >= want) begin
            void'(exp_q[gi].pop_front());
            check($sformatf("vld_timeout_L%0d", lat_of(gi)), 32'(vld[gi]), 32'd1);
          end
        end else begin
          check($sformatf("vld_idle_L%0d", lat_of(gi)), 32'(vld[gi]), 32'd0);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 3'b111 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("ready_wait", 32'(ready), 32'd7);
  endtask

  task automatic do_req(input logic w, input logic [1:0] wd, input logic s,
                        input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    wait_ready();
    e     = model(w, wd, s, a, d);
    req   = 1'b1;
    wen   = w;
    width = wd;
    sgn   = s;
    adr   = a;
    wdat  = d;
    @(posedge clk);
    #1;
    e.acc = 32'(cycle);
    for (int i = 0; i < 3; i++) exp_q[i].push_back(e);
    req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] ra;

    // Reset: ready held low while reset is asserted.
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 32'(ready), 32'd0);
    check("vld_in_reset", 32'(vld), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(ready), 32'd7);
    mon_en = 1'b1;

    // Fill a working window so random loads read defined data.
    for (int i = 0; i < 64; i++) do_req(1'b1, 2'd2, 1'b0, 16'(4 * i), $urandom);

    // Word store/load round trip.
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h1234_5678);
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0);
    // Byte store into the middle of a word, then loads of each size.
    do_req(1'b1, 2'd0, 1'b0, 16'h0011, 32'h0000_00F7);
    do_req(1'b0, 2'd0, 1'b1, 16'h0011, 32'd0);
    do_req(1'b0, 2'd0, 1'b0, 16'h0011, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0);
    // Signed upper half, then misaligned half.
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'h8001_5A5A);
    do_req(1'b0, 2'd1, 1'b1, 16'h0012, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 16'h0011, 32'd0);
    // Word store with width code 3, misaligned word store must not disturb.
    do_req(1'b1, 2'd3, 1'b0, 16'h0014, 32'hDEAD_BEEF);
    do_req(1'b1, 2'd2, 1'b0, 16'h0016, 32'h0BAD_0BAD);
    do_req(1'b0, 2'd2, 1'b0, 16'h0014, 32'd0);
    // Address range boundary.
    do_req(1'b0, 2'd2, 1'b0, 16'(NBYTES), 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 16'(NBYTES - 4), 32'hA5C3_8E11);
    do_req(1'b0, 2'd2, 1'b0, 16'(NBYTES - 4), 32'd0);
    do_req(1'b0, 2'd0, 1'b1, 16'(NBYTES - 1), 32'd0);
    do_req(1'b0, 2'd1, 1'b1, 16'(NBYTES - 2), 32'd0);

    // Reset one cycle after a load accept; a store requested during reset is dropped.
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0);
    rstn  = 1'b0;
    req   = 1'b1;
    wen   = 1'b1;
    width = 2'd0;
    adr   = 16'h0020;
    wdat  = 32'h0000_0099;
    @(posedge clk);
    #1;
    check("ready_mid_reset", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check("vld_mid_reset", 32'(vld), 32'd0);
    rstn = 1'b1;
    req  = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_abort", 32'(ready), 32'd7);
    do_req(1'b0, 2'd0, 1'b0, 16'h0020, 32'd0);

    // A request held while busy is ignored, not queued.
    do_req(1'b0, 2'd2, 1'b0, 16'h0024, 32'd0);
    req   = 1'b1;
    wen   = 1'b1;
    width = 2'd2;
    adr   = 16'h0024;
    wdat  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 16'h0024, 32'd0);

    // Randomized traffic over the window plus occasional out-of-range addresses.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(15) == 0) ra = 16'(NBYTES + $urandom_range(255));
      else ra = 16'($urandom_range(255));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
    end

    // Drain outstanding responses.
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20) check("drain", 32'(exp_q[2].size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmemory_banked.md
DMEMORY_BANKED -- requirements
Module: dmemory_banked

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of ram_adr_i.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two, 4*DEPTH_WORDS <= 2**ADDR_W.
REQ-003 Parameter READ_LAT, default 2, read latency in cycles from request acceptance to ram_vld_o; legal range 1..4.
REQ-004 Clock, reset and polarity: one clock, ram_clk_i; reset ram_rstn_i is synchronous and active-low.
REQ-005 ram_clk_i  in  1  clock, all state updates on rising edge.
REQ-006 ram_rstn_i  in  1  synchronous active-low reset.
REQ-007 ram_req_i  in  1  request valid.
REQ-008 ram_wen_i  in  1  1 = store, 0 = load; sampled with ram_req_i.
REQ-009 ram_dat_width  in  2  0 byte, 1 halfword, 2 or 3 word.
REQ-010 ram_sign  in  1  load sign-extend (1) or zero-extend (0); ignored for word and stores.
REQ-011 ram_adr_i  in  ADDR_W  byte address, little-endian.
REQ-012 ram_dat_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 ram_ready_o  out  1  block can accept a request this cycle.
REQ-014 ram_vld_o  out  1  one-cycle response pulse for every accepted request.
REQ-015 ram_err_o  out  1  response is an error; valid only with ram_vld_o.
REQ-016 ram_dat_o  out  32  load result; valid only with ram_vld_o.

Function
REQ-017 FSM states IDLE, BUSY, RESP; ram_ready_o = 1 only in IDLE.
REQ-018 Request accepted on edge where ram_req_i && ram_ready_o; inputs captured at that edge; ram_req_i while not ready is ignored (not queued).
REQ-019 Error when: half with adr[0]=1; word with adr[1:0]!=0; or adr >= 4*DEPTH_WORDS.
REQ-020 Error or store: IDLE -> RESP at acceptance edge; ram_vld_o=1 exactly one cycle later (latency 1).
REQ-021 Valid store writes only addressed byte lanes at the acceptance edge: byte -> lane adr[1:0], half -> lanes {adr[1],0} and {adr[1],1}, word -> all four; other lanes unchanged.
REQ-022 Errored request never modifies memory; response ram_err_o=1, ram_dat_o=0.
REQ-023 Valid load: IDLE -> BUSY with latency counter loaded to READ_LAT-1; counter decrements each cycle; BUSY -> RESP when counter reaches 0; READ_LAT=1 goes IDLE -> RESP directly.
REQ-024 ram_vld_o asserted in RESP only, exactly READ_LAT cycles after acceptance for loads; RESP -> IDLE unconditionally next edge.
REQ-025 Load data: selected byte/half shifted to bit 0; upper bits filled with selected MSB if ram_sign=1, else zero; word returned as stored.
REQ-026 Load returns memory contents as of acceptance edge (captured then or memory not written meanwhile, since single outstanding request).
REQ-027 Store response: ram_err_o=0, ram_dat_o=0.
REQ-028 Minimum spacing between accepted requests: 2 cycles (store/error), READ_LAT+1 cycles (load).
REQ-029 Outside RESP: ram_vld_o=0, ram_err_o=0, ram_dat_o=0.

Reset
REQ-030 While ram_rstn_i=0 at a rising edge: state=IDLE, counter=0, ram_vld_o=0, ram_err_o=0, ram_dat_o=0; ram_ready_o=1 from the cycle after reset released... and during reset ram_ready_o=0.
REQ-031 Reset mid-operation (BUSY or RESP) aborts the request with no response pulse; store already committed stays committed.
REQ-032 Memory array is not reset; contents after power-up are undefined unless preloaded.
REQ-033 Request asserted in the same cycle reset is low is not accepted.

Verification
REQ-034 Word store 0x12345678 at 0x0010, then word load 0x0010 -> vld after READ_LAT cycles, dat=0x12345678, err=0.
REQ-035 Byte store 0x000000F7 at 0x0011 over 0x12345678, byte load 0x0011 sign=1 -> 0xFFFFFFF7; sign=0 -> 0x000000F7; word load -> 0x1234F778.
REQ-036 Half load at 0x0012 sign=1 from word 0x8001xxxx -> 0xFFFF8001; half load at 0x0011 -> vld one cycle after accept, err=1, dat=0.
REQ-037 Word store 0xDEADBEEF at 0x0014 with dat_width=3 -> stored; word store at 0x0016 -> err=1, word at 0x0014 still 0xDEADBEEF.
REQ-038 Load address 4*DEPTH_WORDS -> err=1; reset driven low one cycle after a valid load accept -> no vld pulse, ready=1 after reset release.
REQ-039 Sweep READ_LAT=1 and 4: measured acceptance-to-vld equals READ_LAT; ready low from acceptance through RESP cycle.
